wishbone_dma: RTL and testbench



---
 rtl/wishbone_dma_if.sv | 24 ++
 rtl/wishbone_dma.sv | 188 ++++++++++++++++++
 tb/tb_wishbone_dma.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_dma_if.sv
// Pipelined Wishbone bundle shared by the CPU config path and the DMA copy path.
// The master drives requests and write data; the slave drives responses and read data.
interface wishbone_interface;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output cyc, stb, adr, sel, we, dat_mosi,
        input  dat_miso, ack, stall, err
    );

    modport slave (
        input  cyc, stb, adr, sel, we, dat_mosi,
        output dat_miso, ack, stall, err
    );
endinterface

// File: rtl/wishbone_dma.sv
// Memory-to-memory word copy engine: CPU programs SRC/DST/LEN/CTRL over a slave window,
// and the engine copies one word at a time over its own Wishbone master port.
module wishbone_dma #(
    parameter logic [31:0] ADDRESS = 32'h0,
    parameter logic [31:0] SIZE    = 32'h10
) (
    input  logic              clk,
    input  logic              rst_n,
    wishbone_interface.slave  config_port,
    wishbone_interface.master dma_port,
    output logic              interrupt
);

    typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait} state_e;

    state_e      state_q;
    logic [31:0] src_q, dst_q, len_q;
    logic        busy_q, done_q, error_q, irq_en_q;

    logic        cfg_ack_q;
    logic [31:0] cfg_rdata_q;

    logic        m_cyc_q, m_stb_q, m_we_q;
    logic [31:0] m_adr_q, m_dat_q;
    logic [3:0]  m_sel_q;

    logic [31:0] offset;
    logic        in_window, cfg_req, cfg_wr, start_req;
    logic [1:0]  reg_idx;
    logic [31:0] rdata;

    assign offset    = config_port.adr - ADDRESS;
    assign in_window = offset < SIZE;
    assign reg_idx   = offset[3:2];
    assign cfg_req   = config_port.cyc & config_port.stb;
    assign cfg_wr    = cfg_req & config_port.we & (config_port.sel == 4'hF) & in_window;
    assign start_req = cfg_wr & (reg_idx == 2'd3) & config_port.dat_mosi[0] & ~busy_q;

    always_comb begin
        rdata = '0;
        if (in_window) begin
            case (reg_idx)
                2'd0:    rdata = src_q;
                2'd1:    rdata = dst_q;
                2'd2:    rdata = len_q;
                default: rdata = {27'd0, irq_en_q, error_q, done_q, busy_q, 1'b0};
            endcase
        end
    end

    // Slave side never stalls: every request is answered exactly one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack_q   <= 1'b0;
            cfg_rdata_q <= '0;
        end else begin
            cfg_ack_q <= cfg_req;
            if (cfg_req) begin
                cfg_rdata_q <= rdata;
            end
        end
    end

    assign config_port.ack      = cfg_ack_q;
    assign config_port.dat_miso = cfg_rdata_q;
    assign config_port.stall    = 1'b0;
    assign config_port.err      = 1'b0;

    // Register writes come first so that hardware updates later in this block win over W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            irq_en_q <= 1'b0;
            m_cyc_q  <= 1'b0;
            m_stb_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_adr_q  <= '0;
            m_sel_q  <= '0;
            m_dat_q  <= '0;
        end else begin
            if (cfg_wr && !busy_q) begin
                case (reg_idx)
                    2'd0:    src_q <= {config_port.dat_mosi[31:2], 2'b00};
                    2'd1:    dst_q <= {config_port.dat_mosi[31:2], 2'b00};
                    2'd2:    len_q <= config_port.dat_mosi;
                    default: ;
                endcase
            end
            if (cfg_wr && reg_idx == 2'd3) begin
                if (config_port.dat_mosi[2]) done_q  <= 1'b0;
                if (config_port.dat_mosi[3]) error_q <= 1'b0;
                irq_en_q <= config_port.dat_mosi[4];
            end

            case (state_q)
                StIdle: begin
                    if (start_req) begin
                        if (len_q != 32'd0) begin
                            busy_q  <= 1'b1;
                            state_q <= StRdReq;
                            m_cyc_q <= 1'b1;
                            m_stb_q <= 1'b1;
                            m_we_q  <= 1'b0;
                            m_adr_q <= src_q;
                            m_sel_q <= 4'hF;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRdReq: begin
                    if (!dma_port.stall) begin
                        m_stb_q <= 1'b0;
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (dma_port.err) begin
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        m_sel_q <= '0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= StIdle;
                    end else if (dma_port.ack) begin
                        m_dat_q <= dma_port.dat_miso;
                        m_stb_q <= 1'b1;
                        m_we_q  <= 1'b1;
                        m_adr_q <= dst_q;
                        state_q <= StWrReq;
                    end
                end
                StWrReq: begin
                    if (!dma_port.stall) begin
                        m_stb_q <= 1'b0;
                        state_q <= StWrWait;
                    end
                end
                StWrWait: begin
                    if (dma_port.err) begin
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        m_sel_q <= '0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= StIdle;
                    end else if (dma_port.ack) begin
                        src_q <= src_q + 32'd4;
                        dst_q <= dst_q + 32'd4;
                        len_q <= len_q - 32'd1;
                        if (len_q == 32'd1) begin
                            m_cyc_q <= 1'b0;
                            m_we_q  <= 1'b0;
                            m_sel_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            m_stb_q <= 1'b1;
                            m_we_q  <= 1'b0;
                            m_adr_q <= src_q + 32'd4;
                            state_q <= StRdReq;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dma_port.cyc      = m_cyc_q;
    assign dma_port.stb      = m_stb_q;
    assign dma_port.we       = m_we_q;
    assign dma_port.adr      = m_adr_q;
    assign dma_port.sel      = m_sel_q;
    assign dma_port.dat_mosi = m_dat_q;

    assign interrupt = irq_en_q & (done_q | error_q);

endmodule

// File: tb/tb_wishbone_dma.sv
// Bench for wishbone_dma: drives the config window from tasks, models RAM on the copy port,
// and scores observed write beats and register reads against bench-side expectations.
module tb_wishbone_dma;

    localparam logic [31:0] BASE     = 32'h4000_0000;
    localparam logic [31:0] OFF_SRC  = 32'h0;
    localparam logic [31:0] OFF_DST  = 32'h4;
    localparam logic [31:0] OFF_LEN  = 32'h8;
    localparam logic [31:0] OFF_CTRL = 32'hC;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wishbone_interface cfg ();
    wishbone_interface dma ();

    wishbone_dma #(.ADDRESS(BASE), .SIZE(32'h10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .config_port(cfg),
        .dma_port   (dma),
        .interrupt  (irq)
    );

    always #5 clk = ~clk;

    // RAM model on the copy port
    logic [31:0] mem [0:1023];
    int          stall_cycles = 0;
    int          err_at       = 0;
    int          rd_count     = 0;
    int          wr_count     = 0;
    int          cyc_count    = 0;
    int          stall_viol   = 0;
    int          stall_seen   = 0;
    int          stall_cnt    = 0;
    logic        hold_valid   = 1'b0;
    logic [31:0] h_adr, h_dat;
    logic        h_we;
    logic        err_d1        = 1'b0;
    logic        cyc_after_err = 1'b1;
    logic [63:0] obs_wr [$];
    logic [63:0] exp_wr [$];
    logic [31:0] exp_q  [$];

    assign dma.stall = dma.cyc & dma.stb & (stall_cnt < stall_cycles);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma.ack      <= 1'b0;
            dma.err      <= 1'b0;
            dma.dat_miso <= '0;
            stall_cnt    <= 0;
            hold_valid   <= 1'b0;
            err_d1       <= 1'b0;
        end else begin
            dma.ack <= 1'b0;
            dma.err <= 1'b0;
            err_d1  <= dma.err;
            if (err_d1) cyc_after_err <= dma.cyc;
            if (dma.cyc) cyc_count <= cyc_count + 1;
            if (hold_valid && (!dma.stb || dma.adr !== h_adr || dma.we !== h_we ||
                               dma.dat_mosi !== h_dat)) begin
                stall_viol <= stall_viol + 1;
            end
            if (dma.cyc && dma.stb && dma.stall) begin
                hold_valid <= 1'b1;
                h_adr      <= dma.adr;
                h_we       <= dma.we;
                h_dat      <= dma.dat_mosi;
                stall_cnt  <= stall_cnt + 1;
                stall_seen <= stall_seen + 1;
            end else begin
                hold_valid <= 1'b0;
                if (dma.cyc && dma.stb) begin
                    stall_cnt <= 0;
                    if (dma.we) begin
                        wr_count <= wr_count + 1;
                        obs_wr.push_back({dma.adr, dma.dat_mosi});
                        dma.ack <= 1'b1;
                    end else begin
                        rd_count <= rd_count + 1;
                        if (rd_count + 1 == err_at) begin
                            dma.err <= 1'b1;
                        end else begin
                            dma.ack      <= 1'b1;
                            dma.dat_miso <= mem[dma.adr[11:2]];
                        end
                    end
                end
            end
        end
    end

    // Config bus access; caller is aligned 1 time unit after a rising edge.
    task automatic cfg_write(input logic [31:0] off, input logic [31:0] data,
                             input logic [3:0] sel);
        cfg.cyc = 1'b1; cfg.stb = 1'b1; cfg.we = 1'b1;
        cfg.adr = BASE + off; cfg.dat_mosi = data; cfg.sel = sel;
        @(posedge clk); #1;
        cfg.cyc = 1'b0; cfg.stb = 1'b0; cfg.we = 1'b0;
    endtask

    task automatic cfg_read(input logic [31:0] off, output logic [32:0] resp);
        cfg.cyc = 1'b1; cfg.stb = 1'b1; cfg.we = 1'b0;
        cfg.adr = BASE + off; cfg.sel = 4'hF;
        @(posedge clk); #1;
        resp = {cfg.ack, cfg.dat_miso};
        cfg.cyc = 1'b0; cfg.stb = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!dma.cyc) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_expected(input logic [31:0] src, input logic [31:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [9:0] w;
            w = src[11:2] + 10'(i);
            exp_wr.push_back({dst + 32'(4 * i), mem[w]});
        end
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        obs_wr.delete();
        exp_wr.delete();
        push_expected(src, dst, n);
        cfg_write(OFF_SRC, src, 4'hF);
        cfg_write(OFF_DST, dst, 4'hF);
        cfg_write(OFF_LEN, 32'(n), 4'hF);
        cfg_write(OFF_CTRL, 32'h1, 4'hF);
    endtask

    task automatic test_reset();
        logic [32:0] resp;
        logic [31:0] e;
        cfg.cyc = 1'b0; cfg.stb = 1'b0; cfg.we = 1'b0;
        cfg.adr = '0; cfg.sel = '0; cfg.dat_mosi = '0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({dma.cyc, dma.stb, dma.we, dma.adr, dma.sel, dma.dat_mosi, cfg.ack, cfg.dat_miso, irq}
            !== '0) $display("FAIL reset_outputs: got nonzero outputs adr=%h cyc=%b ack=%b irq=%b want all 0",
                             dma.adr, dma.cyc, cfg.ack, irq);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            cfg_read(32'(4 * i), resp);
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== {1'b1, e}) $display("FAIL reset_reg%0d: got ack/data %h want %h", i, resp, {1'b1, e});
            else pass_cnt++;
        end
    endtask

    task automatic test_registers();
        logic [31:0] offs [6] = '{OFF_SRC, OFF_DST, OFF_LEN, OFF_SRC, OFF_CTRL, OFF_CTRL};
        logic [31:0] wdat [6] = '{32'h1237, 32'hFFFF_FFFF, 32'h5, 32'hAAAA, 32'hFFFF_FFE0, 32'h10};
        logic [3:0]  sels [6] = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hF, 4'hF};
        logic [31:0] expv [6] = '{32'h1234, 32'hFFFF_FFFC, 32'h5, 32'h1234, 32'h0, 32'h10};
        logic [32:0] resp;
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            cfg_write(offs[i], wdat[i], sels[i]);
            exp_q.push_back(expv[i]);
            cfg_read(offs[i], resp);
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== {1'b1, e}) $display("FAIL regs_%0d: got ack/data %h want %h", i, resp, {1'b1, e});
            else pass_cnt++;
        end
        cfg_write(OFF_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_copy();
        logic [31:0] offs [5] = '{OFF_CTRL, OFF_CTRL, OFF_SRC, OFF_DST, OFF_LEN};
        logic [31:0] expv [5] = '{32'h2, 32'h4, 32'h110, 32'h210, 32'h0};
        logic [32:0] resp;
        logic [31:0] e;
        logic [63:0] e64, o64;
        start_copy(32'h100, 32'h200, 4);
        cycles(15);
        // First read samples the final-ack edge, the second the edge after it.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(expv[i]);
            cfg_read(offs[i], resp);
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== {1'b1, e}) $display("FAIL copy_reg%0d: got ack/data %h want %h", i, resp, {1'b1, e});
            else pass_cnt++;
        end
        total_cnt++;
        if (dma.cyc !== 1'b0) $display("FAIL copy_cyc_idle: got %b want 0", dma.cyc);
        else pass_cnt++;
        total_cnt++;
        if (obs_wr.size() != exp_wr.size())
            $display("FAIL copy_write_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        else pass_cnt++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e64 = exp_wr.pop_front();
            o64 = obs_wr.pop_front();
            total_cnt++;
            if (o64 !== e64) $display("FAIL copy_write: got adr/data %h want %h", o64, e64);
            else pass_cnt++;
        end
        cfg_write(OFF_CTRL, 32'h4, 4'hF);
    endtask

    task automatic test_zero_len();
        logic [32:0] resp;
        logic [31:0] e;
        int c0;
        c0 = cyc_count;
        cfg_write(OFF_LEN, 32'h0, 4'hF);
        cfg_write(OFF_CTRL, 32'h11, 4'hF);
        exp_q.push_back(32'h14);
        cfg_read(OFF_CTRL, resp);
        e = exp_q.pop_front();
        total_cnt++;
        if (resp !== {1'b1, e}) $display("FAIL zero_len_ctrl: got ack/data %h want %h", resp, {1'b1, e});
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL zero_len_irq: got %b want 1", irq);
        else pass_cnt++;
        total_cnt++;
        if (cyc_count != c0) $display("FAIL zero_len_no_cyc: got %0d cyc cycles want 0", cyc_count - c0);
        else pass_cnt++;
        cfg_write(OFF_CTRL, 32'h14, 4'hF);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL zero_len_irq_clear: got %b want 0", irq);
        else pass_cnt++;
        cfg_write(OFF_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_bus_error();
        logic [31:0] offs [4] = '{OFF_CTRL, OFF_SRC, OFF_DST, OFF_LEN};
        logic [31:0] expv [4] = '{32'h8, 32'h304, 32'h404, 32'h2};
        logic [32:0] resp;
        logic [31:0] e;
        logic [63:0] e64, o64;
        bit ok;
        err_at = rd_count + 2;
        start_copy(32'h300, 32'h400, 3);
        exp_wr.delete();
        push_expected(32'h300, 32'h400, 1);
        wait_idle(100, ok);
        total_cnt++;
        if (!ok) $display("FAIL err_timeout: got cyc still high want idle within 100 cycles");
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(expv[i]);
            cfg_read(offs[i], resp);
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== {1'b1, e}) $display("FAIL err_reg%0d: got ack/data %h want %h", i, resp, {1'b1, e});
            else pass_cnt++;
        end
        total_cnt++;
        if (cyc_after_err !== 1'b0) $display("FAIL err_cyc_drop: got cyc=%b after err want 0", cyc_after_err);
        else pass_cnt++;
        total_cnt++;
        if (obs_wr.size() != 1) $display("FAIL err_write_count: got %0d want 1", obs_wr.size());
        else pass_cnt++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e64 = exp_wr.pop_front();
            o64 = obs_wr.pop_front();
            total_cnt++;
            if (o64 !== e64) $display("FAIL err_write: got adr/data %h want %h", o64, e64);
            else pass_cnt++;
        end
        err_at = 0;
        cfg_write(OFF_CTRL, 32'h8, 4'hF);
    endtask

    task automatic test_stall();
        logic [31:0] offs [4] = '{OFF_CTRL, OFF_SRC, OFF_DST, OFF_LEN};
        logic [31:0] expv [4] = '{32'h4, 32'h50C, 32'h60C, 32'h0};
        logic [32:0] resp;
        logic [31:0] e;
        logic [63:0] e64, o64;
        int sv0, ss0;
        bit ok;
        stall_cycles = 3;
        sv0 = stall_viol;
        ss0 = stall_seen;
        start_copy(32'h500, 32'h600, 3);
        wait_idle(400, ok);
        total_cnt++;
        if (!ok) $display("FAIL stall_timeout: got cyc still high want idle within 400 cycles");
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(expv[i]);
            cfg_read(offs[i], resp);
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== {1'b1, e}) $display("FAIL stall_reg%0d: got ack/data %h want %h", i, resp, {1'b1, e});
            else pass_cnt++;
        end
        total_cnt++;
        if (stall_viol != sv0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol - sv0);
        else pass_cnt++;
        total_cnt++;
        if (stall_seen - ss0 != 18) $display("FAIL stall_cycles: got %0d want 18", stall_seen - ss0);
        else pass_cnt++;
        total_cnt++;
        if (obs_wr.size() != exp_wr.size())
            $display("FAIL stall_write_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        else pass_cnt++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e64 = exp_wr.pop_front();
            o64 = obs_wr.pop_front();
            total_cnt++;
            if (o64 !== e64) $display("FAIL stall_write: got adr/data %h want %h", o64, e64);
            else pass_cnt++;
        end
        stall_cycles = 0;
        cfg_write(OFF_CTRL, 32'h4, 4'hF);
    endtask

    task automatic test_back_to_back();
        logic [31:0] offs [4] = '{OFF_CTRL, OFF_SRC, OFF_DST, OFF_LEN};
        logic [31:0] expv [4] = '{32'h4, 32'h710, 32'h810, 32'h0};
        logic [32:0] resp;
        logic [31:0] e;
        logic [63:0] e64, o64;
        int c0;
        bit ok;
        stall_cycles = 1;
        start_copy(32'h700, 32'h800, 4);
        cfg_write(OFF_SRC, 32'hDEAD, 4'hF);
        cfg_write(OFF_DST, 32'hBEEF0, 4'hF);
        cfg_write(OFF_LEN, 32'h9, 4'hF);
        cfg_write(OFF_CTRL, 32'h1, 4'hF);
        wait_idle(400, ok);
        total_cnt++;
        if (!ok) $display("FAIL busy_timeout: got cyc still high want idle within 400 cycles");
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(expv[i]);
            cfg_read(offs[i], resp);
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== {1'b1, e}) $display("FAIL busy_reg%0d: got ack/data %h want %h", i, resp, {1'b1, e});
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_wr.size() != exp_wr.size())
            $display("FAIL busy_write_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        else pass_cnt++;
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e64 = exp_wr.pop_front();
            o64 = obs_wr.pop_front();
            total_cnt++;
            if (o64 !== e64) $display("FAIL busy_write: got adr/data %h want %h", o64, e64);
            else pass_cnt++;
        end
        cfg_write(OFF_CTRL, 32'h4, 4'hF);
        c0 = cyc_count;
        cycles(20);
        exp_q.push_back(32'h0);
        cfg_read(OFF_CTRL, resp);
        e = exp_q.pop_front();
        total_cnt++;
        if (resp !== {1'b1, e}) $display("FAIL busy_single_done: got ack/data %h want %h", resp, {1'b1, e});
        else pass_cnt++;
        total_cnt++;
        if (cyc_count != c0) $display("FAIL busy_no_restart: got %0d cyc cycles want 0", cyc_count - c0);
        else pass_cnt++;
        stall_cycles = 0;
    endtask

    task automatic test_reset_mid_transfer();
        logic [32:0] resp;
        logic [31:0] e;
        bit found;
        int c0;
        cfg_write(OFF_LEN, 32'h0, 4'hF);
        cfg_write(OFF_CTRL, 32'h11, 4'hF);
        cfg_write(OFF_SRC, 32'h900, 4'hF);
        cfg_write(OFF_DST, 32'hA00, 4'hF);
        cfg_write(OFF_LEN, 32'h2, 4'hF);
        cfg_write(OFF_CTRL, 32'h11, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (dma.cyc && dma.we && !dma.stb) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (!found) $display("FAIL rst_wr_wait: got no write-wait cycle want one within 50 cycles");
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL rst_irq_before: got %b want 1", irq);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({dma.cyc, dma.stb, irq} !== 3'b000)
            $display("FAIL rst_async: got cyc/stb/irq %b want 000", {dma.cyc, dma.stb, irq});
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            cfg_read(32'(4 * i), resp);
            e = exp_q.pop_front();
            total_cnt++;
            if (resp !== {1'b1, e}) $display("FAIL rst_reg%0d: got ack/data %h want %h", i, resp, {1'b1, e});
            else pass_cnt++;
        end
        c0 = cyc_count;
        cycles(10);
        total_cnt++;
        if (cyc_count != c0) $display("FAIL rst_idle: got %0d cyc cycles want 0", cyc_count - c0);
        else pass_cnt++;
        obs_wr.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish before 1000000 time units");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[10'(i)] = $urandom;
        test_reset();
        test_registers();
        test_copy();
        test_zero_len();
        test_bus_error();
        test_stall();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
